// File: rtl/buffer_scheduler_if.sv
// Handshake bundle between the time buffer (master) and the readout scheduler (slave).
interface buffer_scheduler_if;
    logic buf_ready;
    logic buf_valid;
    logic buf_sop;
    logic buf_eop;
    logic source_ready;
    logic buf_reset;

    modport master (
        output buf_ready, buf_valid, buf_sop, buf_eop,
        input  source_ready, buf_reset
    );

    modport slave (
        input  buf_ready, buf_valid, buf_sop, buf_eop,
        output source_ready, buf_reset
    );
endinterface

// File: rtl/buffer_scheduler.sv
// Reads RUNS batches out of a time buffer with idle gaps between them, then re-arms it.
// Tracks beat counts per batch and flags length and framing violations as sticky errors.
module buffer_scheduler #(
    parameter int BATCH_SIZE   = 2048,
    parameter int RUNS         = 3,
    parameter int GAP_CYCLES   = 100,
    parameter int REARM_CYCLES = 2
) (
    input  logic                       source_clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear_err,
    buffer_scheduler_if.slave          bus,
    output logic                       batch_done,
    output logic                       runs_done,
    output logic [$clog2(RUNS+1)-1:0]  run_idx,
    output logic [1:0]                 state,
    output logic                       len_err,
    output logic                       seq_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2,
        REARM  = 2'd3
    } state_t;

    localparam int CNT_W   = $clog2(BATCH_SIZE + 1);
    localparam int RUN_W   = $clog2(RUNS + 1);
    localparam int TMR_MAX = (GAP_CYCLES > REARM_CYCLES) ? GAP_CYCLES : REARM_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] LEN_FULL   = CNT_W'(BATCH_SIZE);
    localparam logic [RUN_W-1:0] RUN_LAST   = RUN_W'(RUNS - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] REARM_LAST = TMR_W'(REARM_CYCLES - 1);

    state_t           st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_beat;
    logic [RUN_W-1:0] run_idx_n;
    logic [TMR_W-1:0] tmr, tmr_n;
    logic             batch_done_n, runs_done_n;
    logic             len_err_n, seq_err_n;
    logic             len_hit, seq_hit;
    logic             src_rdy_q, buf_reset_q;

    // Beat counter sticks at all-ones so an overlong batch can never alias back to a legal length.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        st_n         = st;
        cnt_n        = cnt;
        run_idx_n    = run_idx;
        tmr_n        = tmr;
        batch_done_n = 1'b0;
        runs_done_n  = 1'b0;
        len_hit      = 1'b0;
        seq_hit      = 1'b0;
        cnt_beat     = bus.buf_sop ? CNT_W'(1) : sat_inc(cnt);

        case (st)
            IDLE: begin
                if (enable && bus.buf_ready) st_n = STREAM;
            end
            STREAM: begin
                if (bus.buf_valid) begin
                    if (bus.buf_sop && (cnt != '0)) seq_hit = 1'b1;
                    cnt_n = cnt_beat;
                    if (bus.buf_eop) begin
                        len_hit      = (cnt_beat != LEN_FULL);
                        cnt_n        = '0;
                        batch_done_n = 1'b1;
                        run_idx_n    = run_idx + RUN_W'(1);
                        tmr_n        = '0;
                        if (run_idx == RUN_LAST) begin
                            st_n        = REARM;
                            runs_done_n = 1'b1;
                        end else begin
                            st_n = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (tmr == GAP_LAST) begin
                    st_n  = enable ? STREAM : IDLE;
                    tmr_n = '0;
                end else begin
                    tmr_n = tmr + TMR_W'(1);
                end
            end
            REARM: begin
                if (tmr == REARM_LAST) begin
                    st_n      = IDLE;
                    run_idx_n = '0;
                    tmr_n     = '0;
                end else begin
                    tmr_n = tmr + TMR_W'(1);
                end
            end
            default: st_n = IDLE;
        endcase

        // Beats arriving while not streaming are dropped but still flagged.
        if (bus.buf_valid && (st != STREAM)) seq_hit = 1'b1;

        len_err_n = (len_err && !clear_err) || len_hit;
        seq_err_n = (seq_err && !clear_err) || seq_hit;
    end

    always_ff @(posedge source_clk or posedge reset) begin
        if (reset) begin
            st          <= IDLE;
            cnt         <= '0;
            run_idx     <= '0;
            tmr         <= '0;
            batch_done  <= 1'b0;
            runs_done   <= 1'b0;
            len_err     <= 1'b0;
            seq_err     <= 1'b0;
            src_rdy_q   <= 1'b0;
            buf_reset_q <= 1'b0;
        end else begin
            st          <= st_n;
            cnt         <= cnt_n;
            run_idx     <= run_idx_n;
            tmr         <= tmr_n;
            batch_done  <= batch_done_n;
            runs_done   <= runs_done_n;
            len_err     <= len_err_n;
            seq_err     <= seq_err_n;
            src_rdy_q   <= (st_n == STREAM);
            buf_reset_q <= (st_n == REARM);
        end
    end

    assign state            = st;
    assign bus.source_ready = src_rdy_q;
    assign bus.buf_reset    = buf_reset_q;

endmodule

// File: tb/tb_buffer_scheduler.sv
// Randomised bench for buffer_scheduler: a phase/countdown reference model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_buffer_scheduler;
    localparam int BATCH = 2048;
    localparam int RUNS  = 3;
    localparam int GAP   = 100;
    localparam int REARM = 2;

    logic       source_clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear_err;
    logic       batch_done, runs_done, len_err, seq_err;
    logic [1:0] run_idx, state;

    buffer_scheduler_if bif();

    buffer_scheduler #(
        .BATCH_SIZE(BATCH), .RUNS(RUNS), .GAP_CYCLES(GAP), .REARM_CYCLES(REARM)
    ) dut (
        .source_clk(source_clk),
        .reset(reset),
        .enable(enable),
        .clear_err(clear_err),
        .bus(bif),
        .batch_done(batch_done),
        .runs_done(runs_done),
        .run_idx(run_idx),
        .state(state),
        .len_err(len_err),
        .seq_err(seq_err)
    );

    always #5 source_clk = ~source_clk;

    // Reference model: phase 0..3, beats seen so far, batches finished, cycles left in a timed phase.
    int m_phase = 0, m_len = 0, m_runs = 0, m_wait = 0;
    bit m_done = 0, m_rdone = 0, m_len_err = 0, m_seq_err = 0;

    always @(posedge source_clk or posedge reset) begin : model
        bit ne_len, ne_seq;
        if (reset) begin
            m_phase = 0; m_len = 0; m_runs = 0; m_wait = 0;
            m_done = 0; m_rdone = 0; m_len_err = 0; m_seq_err = 0;
        end else begin
            ne_len = 0; ne_seq = 0;
            m_done = 0; m_rdone = 0;
            if (bif.buf_valid && m_phase != 1) ne_seq = 1;
            case (m_phase)
                0: if (enable && bif.buf_ready) m_phase = 1;
                1: if (bif.buf_valid) begin
                    if (bif.buf_sop) begin
                        if (m_len != 0) ne_seq = 1;
                        m_len = 1;
                    end else begin
                        m_len = m_len + 1;
                    end
                    if (bif.buf_eop) begin
                        if (m_len != BATCH) ne_len = 1;
                        m_len  = 0;
                        m_runs = m_runs + 1;
                        m_done = 1;
                        if (m_runs == RUNS) begin
                            m_rdone = 1; m_phase = 3; m_wait = REARM;
                        end else begin
                            m_phase = 2; m_wait = GAP;
                        end
                    end
                end
                2: begin
                    m_wait = m_wait - 1;
                    if (m_wait == 0) m_phase = enable ? 1 : 0;
                end
                default: begin
                    m_wait = m_wait - 1;
                    if (m_wait == 0) begin m_runs = 0; m_phase = 0; end
                end
            endcase
            m_len_err = (clear_err ? 1'b0 : m_len_err) | ne_len;
            m_seq_err = (clear_err ? 1'b0 : m_seq_err) | ne_seq;
        end
    end

    int checks = 0, errors = 0;
    int ev_done = 0, ev_rdone = 0, ev_brst = 0, gap_run = 0, last_gap = 0, n_gaps = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic compare_cycle();
        logic [9:0] a_vec, e_vec;
        a_vec = {state, bif.source_ready, bif.buf_reset, batch_done, runs_done, run_idx, len_err, seq_err};
        e_vec = {m_phase[1:0], m_phase == 1, m_phase == 3, m_done, m_rdone, m_runs[1:0], m_len_err, m_seq_err};
        checks++;
        if (a_vec !== e_vec) begin
            errors++;
            $display("FAIL cycle_outputs @%0t: got %b, required %b (state,src_rdy,buf_reset,done,runs_done,run_idx,len_err,seq_err)",
                     $time, a_vec, e_vec);
        end
        ev_done  += int'(batch_done);
        ev_rdone += int'(runs_done);
        ev_brst  += int'(bif.buf_reset);
        if (state == 2'd2) begin
            gap_run++;
        end else if (gap_run != 0) begin
            last_gap = gap_run;
            n_gaps++;
            gap_run = 0;
        end
    endtask

    task automatic tick();
        @(negedge source_clk);
        compare_cycle();
        @(posedge source_clk);
        #1;
        bif.buf_valid = 1'b0;
        bif.buf_sop   = 1'b0;
        bif.buf_eop   = 1'b0;
        clear_err     = 1'b0;
    endtask

    task automatic wait_ready(input bit rnd);
        int k;
        k = 0;
        enable = 1'b1;
        while (!bif.source_ready) begin
            if (k == 400) begin
                checks++; errors++;
                $display("FAIL wait_ready: source_ready=0, required 1 within 400 cycles");
                return;
            end
            if (rnd) begin
                bif.buf_ready = 1'($urandom_range(1));
                if ($urandom_range(15) == 0) bif.buf_valid = 1'b1;
            end else begin
                bif.buf_ready = 1'b1;
            end
            tick();
            k++;
        end
        bif.buf_ready = 1'b1;
    endtask

    task automatic wait_state(input logic [1:0] st, input int limit);
        int k;
        k = 0;
        while (state != st) begin
            if (k == limit) begin
                checks++; errors++;
                $display("FAIL wait_state: state=%0d, required %0d within %0d cycles", state, st, limit);
                return;
            end
            tick();
            k++;
        end
    endtask

    task automatic send_batch(input int n, input int sop2_at, input int drop_at, input int rst_at, input bit rnd);
        int i;
        wait_ready(rnd);
        i = 1;
        while (i <= n) begin
            if ($urandom_range(7) == 0) begin
                tick();
                continue;
            end
            bif.buf_valid = 1'b1;
            bif.buf_sop   = (i == 1) || (i == sop2_at);
            bif.buf_eop   = (i == n);
            if (rnd) clear_err = ($urandom_range(15) == 0);
            if (i == drop_at) enable = 1'b0;
            if (i == rst_at) begin
                bif.buf_valid = 1'b0; bif.buf_sop = 1'b0; bif.buf_eop = 1'b0;
                #2 reset = 1'b1;
                #1;
                chk("async_rst_state", state, 0);
                chk("async_rst_src_rdy", bif.source_ready, 0);
                chk("async_rst_run_idx", run_idx, 0);
                chk("async_rst_buf_reset", bif.buf_reset, 0);
                chk("async_rst_batch_done", batch_done, 0);
                tick();
                tick();
                reset = 1'b0;
                return;
            end
            tick();
            i++;
        end
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s_done, s_rdone, s_brst, s_gaps, n, ridx;
        int lens[5] = '{1, 2047, 2048, 2048, 2049};

        reset = 1'b1; enable = 1'b0; clear_err = 1'b0;
        bif.buf_ready = 1'b0; bif.buf_valid = 1'b0; bif.buf_sop = 1'b0; bif.buf_eop = 1'b0;
        tick(); tick(); tick();
        chk("reset_state", state, 0);
        chk("reset_src_rdy", bif.source_ready, 0);
        chk("reset_run_idx", run_idx, 0);
        chk("reset_errs", {len_err, seq_err}, 0);
        reset = 1'b0;
        tick(); tick();
        chk("post_reset_idle", state, 0);
        chk("post_reset_no_rearm", bif.buf_reset, 0);

        // Three clean batches through to re-arm.
        s_done = ev_done; s_rdone = ev_rdone; s_brst = ev_brst; s_gaps = n_gaps;
        send_batch(BATCH, 0, 0, 0, 0);
        chk("b1_done", batch_done, 1);
        chk("b1_run_idx", run_idx, 1);
        chk("b1_gap", state, 2);
        send_batch(BATCH, 0, 0, 0, 0);
        chk("b2_run_idx", run_idx, 2);
        send_batch(BATCH, 0, 0, 0, 0);
        chk("b3_runs_done", runs_done, 1);
        chk("b3_run_idx", run_idx, 3);
        chk("b3_rearm", state, 3);
        wait_state(2'd0, 10);
        chk("rearm_run_idx", run_idx, 0);
        tick();
        chk("s1_done_count", ev_done - s_done, 3);
        chk("s1_runs_done_count", ev_rdone - s_rdone, 1);
        chk("s1_buf_reset_cycles", ev_brst - s_brst, 2);
        chk("s1_gap_count", n_gaps - s_gaps, 2);
        chk("s1_gap_len", last_gap, GAP);

        // Short batch, then clear.
        send_batch(BATCH - 1, 0, 0, 0, 0);
        chk("short_done", batch_done, 1);
        chk("short_len_err", len_err, 1);
        clear_err = 1'b1;
        tick();
        chk("short_cleared", len_err, 0);

        // Restarted batch: second sop at beat 10, then a full batch from it.
        send_batch(BATCH + 9, 10, 0, 0, 0);
        chk("resop_seq_err", seq_err, 1);
        chk("resop_len_ok", len_err, 0);
        chk("resop_run_idx", run_idx, 2);
        clear_err = 1'b1;
        tick();
        chk("resop_cleared", seq_err, 0);
        send_batch(BATCH, 0, 0, 0, 0);
        chk("s3_runs_done", runs_done, 1);

        // Enable dropped mid-batch: batch completes, then idle after the gap.
        send_batch(BATCH, 0, 500, 0, 0);
        chk("drop_done", batch_done, 1);
        chk("drop_gap", state, 2);
        wait_state(2'd0, GAP + 20);
        repeat (5) tick();
        chk("drop_idle", state, 0);
        chk("drop_src_rdy", bif.source_ready, 0);
        chk("drop_gap_len", last_gap, GAP);

        // Asynchronous reset mid-batch, then a fresh count.
        send_batch(BATCH, 0, 0, 0, 0);
        send_batch(BATCH, 0, 0, 1000, 0);
        send_batch(BATCH, 0, 0, 0, 0);
        chk("after_rst_run_idx", run_idx, 1);
        chk("after_rst_errs", {len_err, seq_err}, 0);

        // Stray beat during the gap.
        repeat (3) tick();
        chk("stray_in_gap", state, 2);
        ridx = run_idx;
        bif.buf_valid = 1'b1;
        tick();
        chk("stray_seq_err", seq_err, 1);
        chk("stray_run_idx", run_idx, ridx);
        chk("stray_still_gap", state, 2);
        send_batch(BATCH, 0, 0, 0, 0);
        chk("stray_next_len_ok", len_err, 0);
        chk("stray_next_run_idx", run_idx, 2);
        clear_err = 1'b1;
        tick();
        chk("stray_cleared", seq_err, 0);

        // Single beat carrying both sop and eop is a length-1 batch.
        send_batch(1, 0, 0, 0, 0);
        chk("single_len_err", len_err, 1);
        chk("single_runs_done", runs_done, 1);
        clear_err = 1'b1;
        tick();

        // Randomised batches against the model.
        for (int b = 0; b < 5; b++) begin
            n = lens[$urandom_range(4)];
            send_batch(n, 0, ($urandom_range(3) == 0) ? $urandom_range(n) : 0, 0, 1);
            repeat ($urandom_range(20)) tick();
        end
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
